// File: rtl/fsm_trace_monitor_if.sv
// fsm_trace_monitor_if: observed FSM signals plus the report/status bus of the trace monitor.
interface fsm_trace_monitor_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       state;
    logic             y;
    logic             rpt_ready;
    logic             rpt_valid;
    logic [1:0]       rpt_state;
    logic [CNT_W-1:0] rpt_dwell;
    logic [CNT_W-1:0] pulse_cnt;
    logic             err;
    logic [1:0]       err_from;
    logic [1:0]       err_to;
    logic             ovf;

    modport master (
        output state, y, rpt_ready,
        input  rpt_valid, rpt_state, rpt_dwell, pulse_cnt, err, err_from, err_to, ovf
    );

    modport slave (
        input  state, y, rpt_ready,
        output rpt_valid, rpt_state, rpt_dwell, pulse_cnt, err, err_from, err_to, ovf
    );
endinterface

// File: rtl/fsm_trace_monitor.sv
// fsm_trace_monitor: watches a 2-bit FSM, reports each transition with its dwell time,
// counts y rising edges and flags transitions outside the cyclic order.
module fsm_trace_monitor #(
    parameter int CNT_W = 16,
    parameter int STEP  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    fsm_trace_monitor_if.slave  bus
);
    typedef enum logic {SYNC, TRACK} mode_t;

    localparam logic [1:0]       STEP2 = 2'(STEP);
    localparam logic [CNT_W-1:0] MAX_D = '1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    mode_t            r_mode, w_mode;
    logic [1:0]       r_state_q, w_state_q;
    logic             r_y_q, w_y_q;
    logic [CNT_W-1:0] r_dwell, w_dwell;
    logic             r_rpt_valid, w_rpt_valid;
    logic [1:0]       r_rpt_state, w_rpt_state;
    logic [CNT_W-1:0] r_rpt_dwell, w_rpt_dwell;
    logic [CNT_W-1:0] r_pulse, w_pulse;
    logic             r_err, w_err;
    logic [1:0]       r_err_from, w_err_from;
    logic [1:0]       r_err_to, w_err_to;
    logic             r_ovf, w_ovf;
    logic             w_trans, w_rise, w_pop, w_load, w_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode      <= SYNC;
            r_state_q   <= '0;
            r_y_q       <= 1'b0;
            r_dwell     <= '0;
            r_rpt_valid <= 1'b0;
            r_rpt_state <= '0;
            r_rpt_dwell <= '0;
            r_pulse     <= '0;
            r_err       <= 1'b0;
            r_err_from  <= '0;
            r_err_to    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_mode      <= w_mode;
            r_state_q   <= w_state_q;
            r_y_q       <= w_y_q;
            r_dwell     <= w_dwell;
            r_rpt_valid <= w_rpt_valid;
            r_rpt_state <= w_rpt_state;
            r_rpt_dwell <= w_rpt_dwell;
            r_pulse     <= w_pulse;
            r_err       <= w_err;
            r_err_from  <= w_err_from;
            r_err_to    <= w_err_to;
            r_ovf       <= w_ovf;
        end
    end

    always_comb begin
        w_trans     = (r_mode == TRACK) && (bus.state != r_state_q);
        w_rise      = (r_mode == TRACK) && bus.y && !r_y_q;
        w_pop       = r_rpt_valid && bus.rpt_ready;
        // A transition refills the buffer only if it is empty or being drained this edge
        w_load      = w_trans && (!r_rpt_valid || w_pop);
        w_bad       = w_trans && (bus.state != r_state_q + STEP2);
        w_mode      = i_clr ? SYNC : TRACK;
        w_state_q   = i_clr ? 2'd0 : bus.state;
        w_y_q       = !i_clr && bus.y;
        w_dwell     = i_clr ? '0 :
                      (r_mode == SYNC || w_trans) ? ONE :
                      (r_dwell == MAX_D) ? r_dwell : r_dwell + ONE;
        w_rpt_valid = !i_clr && (w_trans || (r_rpt_valid && !w_pop));
        w_rpt_state = i_clr ? 2'd0 : w_load ? r_state_q : r_rpt_state;
        w_rpt_dwell = i_clr ? '0 : w_load ? r_dwell : r_rpt_dwell;
        w_pulse     = i_clr ? '0 : w_rise ? r_pulse + ONE : r_pulse;
        w_err       = !i_clr && (r_err || w_bad);
        w_err_from  = i_clr ? 2'd0 : (w_bad && !r_err) ? r_state_q : r_err_from;
        w_err_to    = i_clr ? 2'd0 : (w_bad && !r_err) ? bus.state : r_err_to;
        w_ovf       = !i_clr && (r_ovf || (w_trans && !w_load));
    end

    assign bus.rpt_valid = r_rpt_valid;
    assign bus.rpt_state = r_rpt_state;
    assign bus.rpt_dwell = r_rpt_dwell;
    assign bus.pulse_cnt = r_pulse;
    assign bus.err       = r_err;
    assign bus.err_from  = r_err_from;
    assign bus.err_to    = r_err_to;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fsm_trace_monitor.sv
// tb_fsm_trace_monitor: directed plus random stimulus against a run-length reference model,
// with reports checked by a queue-based scoreboard in a separate monitor process.
module tb_fsm_trace_monitor;
    localparam int W    = 4;
    localparam int MAXD = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;

    fsm_trace_monitor_if #(.CNT_W(W)) bus ();

    fsm_trace_monitor #(.CNT_W(W), .STEP(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int d;} rpt_t;
    rpt_t exp_q[$];

    int  n_cmp = 0, n_bad = 0;
    bit  m_sync, m_err, m_ovf, m_full, m_py;
    int  m_prev, m_run, m_pulses, m_ef, m_et;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 1'b1; m_prev = 0; m_py = 1'b0; m_run = 0; m_pulses = 0;
        m_err = 1'b0; m_ef = 0; m_et = 0; m_ovf = 1'b0; m_full = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: reports are runs of equal samples, cut at each change
    task automatic model_step();
        int  s;
        bit  yv, pop;
        rpt_t r;
        s  = int'(bus.state);
        yv = bus.y;
        if (clr) begin
            model_reset();
        end else if (m_sync) begin
            m_sync = 1'b0; m_prev = s; m_py = yv; m_run = 1;
        end else begin
            pop = m_full && bus.rpt_ready;
            if (s != m_prev) begin
                if (s != (m_prev + 1) % 4 && !m_err) begin
                    m_err = 1'b1; m_ef = m_prev; m_et = s;
                end
                r.s = m_prev;
                r.d = (m_run > MAXD) ? MAXD : m_run;
                if (!m_full || pop) begin
                    exp_q.push_back(r);
                    m_full = 1'b1;
                end else m_ovf = 1'b1;
                m_run = 1;
            end else begin
                m_run++;
                if (pop) m_full = 1'b0;
            end
            if (yv && !m_py) m_pulses++;
            m_prev = s; m_py = yv;
        end
    endtask

    always @(negedge clk) begin
        chk("rpt_valid", int'(bus.rpt_valid), int'(m_full));
        if (bus.rpt_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL report: got state %0d dwell %0d expected no report", bus.rpt_state, bus.rpt_dwell);
            end else begin
                chk("rpt_state", int'(bus.rpt_state), exp_q[0].s);
                chk("rpt_dwell", int'(bus.rpt_dwell), exp_q[0].d);
                if (bus.rpt_ready) void'(exp_q.pop_front());
            end
        end
        chk("pulse_cnt", int'(bus.pulse_cnt), m_pulses % (MAXD + 1));
        chk("err", int'(bus.err), int'(m_err));
        chk("err_from", int'(bus.err_from), m_ef);
        chk("err_to", int'(bus.err_to), m_et);
        chk("ovf", int'(bus.ovf), int'(m_ovf));
    end

    task automatic step(input int s, input bit yv, input bit rdy, input bit cl);
        bus.state = 2'(s); bus.y = yv; bus.rpt_ready = rdy; clr = cl;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int cur, r;
        bit yv;
        bus.state = 2'd0; bus.y = 1'b0; bus.rpt_ready = 1'b0;
        model_reset();
        #1 do_reset(3);
        repeat (10) step(0, 0, 1'($urandom % 2), 0);
        chk("t1_valid", int'(bus.rpt_valid), 0);
        chk("t1_dwell", int'(bus.rpt_dwell), 0);
        do_reset(1);
        repeat (5) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("t2_valid", int'(bus.rpt_valid), 1);
        chk("t2_state", int'(bus.rpt_state), 0);
        chk("t2_dwell", int'(bus.rpt_dwell), 5);
        chk("t2_err", int'(bus.err), 0);
        step(1, 0, 1, 0);
        step(3, 0, 1, 0);
        chk("t3_err", int'(bus.err), 1);
        chk("t3_from", int'(bus.err_from), 1);
        chk("t3_to", int'(bus.err_to), 3);
        step(3, 0, 1, 0);
        step(2, 0, 1, 0);
        chk("t3_from_kept", int'(bus.err_from), 1);
        chk("t3_to_kept", int'(bus.err_to), 3);
        step(2, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(k, 0, 0, 0);
            step(k, 0, 0, 0);
        end
        chk("t4_valid", int'(bus.rpt_valid), 1);
        chk("t4_state", int'(bus.rpt_state), 0);
        chk("t4_dwell", int'(bus.rpt_dwell), 2);
        chk("t4_ovf", int'(bus.ovf), 1);
        step(3, 0, 1, 0);
        chk("t4_drained", int'(bus.rpt_valid), 0);
        step(3, 0, 0, 1);
        step(3, 0, 0, 0);
        repeat (7) begin
            step(3, 1, 0, 0);
            step(3, 0, 0, 0);
        end
        chk("t5_pulses", int'(bus.pulse_cnt), 7);
        step(3, 0, 0, 1);
        chk("t5_clr", int'(bus.pulse_cnt), 0);
        step(3, 1, 0, 0);
        chk("t5_sync_edge", int'(bus.pulse_cnt), 0);
        step(3, 1, 0, 0);
        chk("t5_held_high", int'(bus.pulse_cnt), 0);
        step(3, 0, 1, 1);
        repeat (20) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("t6_valid", int'(bus.rpt_valid), 1);
        chk("t6_dwell_sat", int'(bus.rpt_dwell), MAXD);
        rst_n = 1'b0;
        model_reset();
        #1 chk("t6_async_rst", int'(bus.rpt_valid), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cur = 0;
        yv = 1'b0;
        repeat (3000) begin
            r = int'($urandom % 8);
            cur = (r == 0) ? int'($urandom % 4) : (r < 3) ? (cur + 1) % 4 : cur;
            if ($urandom % 3 == 0) yv = ~yv;
            if ($urandom % 600 == 0) do_reset(1 + int'($urandom % 2));
            else step(cur, yv, 1'($urandom % 2), 1'($urandom % 150 == 0));
        end
        @(negedge clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
